// File: rtl/gpio_input_sampler_pkg.sv
// Shared constants and width helpers for the GPIO input sampler.
// Debounce counters and the prescaler are sized from these helpers.
package gpio_input_sampler_pkg;

  localparam int GPIO_WIDTH_DEF   = 8;
  localparam int DEBOUNCE_DIV_DEF = 16;
  localparam int DEBOUNCE_CNT_DEF = 4;

  // Stability counter must be able to hold DEBOUNCE_CNT-1 (and never less than 1 bit).
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/gpio_input_sampler_debounce.sv
// One GPIO bit: two-flop synchroniser, tick-gated stability counter,
// debounced level and registered rise/fall pulses.
module gpio_input_sampler_debounce
  import gpio_input_sampler_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int CW           = cnt_width(DEBOUNCE_CNT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  input  logic tick_i,
  output logic data_o,
  output logic rise_o,
  output logic fall_o
);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Synchroniser chain is a pure pass-through; nothing sits between the flops.
  always_comb begin
    sync1_d = pad_i;
    sync2_d = sync1_q;
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = {CW{1'b0}};
    end else if (tick_i) begin
      if (cnt_q == CW'(DEBOUNCE_CNT - 1)) begin
        level_d = sync2_q;
        cnt_d   = {CW{1'b0}};
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign data_o = level_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/gpio_input_sampler.sv
// GPIO input sampler: shared debounce prescaler, per-bit debouncers,
// edge-enabled interrupt pending register and irq OR.
module gpio_input_sampler
  import gpio_input_sampler_pkg::*;
#(
  parameter int WIDTH        = GPIO_WIDTH_DEF,
  parameter int DEBOUNCE_DIV = DEBOUNCE_DIV_DEF,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad_i,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] pend_clr,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] pending_o,
  output logic             irq_o
);

  localparam int PW = presc_width(DEBOUNCE_DIV);

  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_s;
  logic [WIDTH-1:0] pend_q, pend_d;

  // With DEBOUNCE_DIV=1 the counter stays at 0 == DIV-1, so tick is constantly high.
  always_comb begin
    tick_s = (presc_q == PW'(DEBOUNCE_DIV - 1));
    if (tick_s) begin
      presc_d = {PW{1'b0}};
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_input_sampler_debounce #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .pad_i  (pad_i[i]),
      .tick_i (tick_s),
      .data_o (data_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i])
    );
  end

  // A set in the same cycle as a clear wins.
  always_comb begin
    pend_d = (pend_q & ~pend_clr) | (rise_o & rise_en) | (fall_o & fall_en);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= {PW{1'b0}};
      pend_q  <= {WIDTH{1'b0}};
    end else begin
      presc_q <= presc_d;
      pend_q  <= pend_d;
    end
  end

  assign pending_o = pend_q;
  assign irq_o     = |pend_q;

endmodule
